// File: rtl/recip_sched_pkg.sv
// Shared types and constants for the recip16 round-robin scheduler.
package recip_sched_pkg;

    localparam int unsigned DENOM_W   = 9;
    localparam int unsigned RECIP_W   = 16;
    localparam int unsigned DIV_ITERS = 15;
    localparam int unsigned REM_W     = DENOM_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [REM_W-1:0]   rem;
        logic [RECIP_W-1:0] quo;
    } div_state_t;

    // One restoring-division step on the all-zero tail bits of 65536.
    function automatic div_state_t div_step(input div_state_t s, input logic [DENOM_W-1:0] d);
        logic [REM_W-1:0] rem2;
        div_state_t       n;
        rem2 = {s.rem[REM_W-2:0], 1'b0};
        if (rem2 >= {1'b0, d}) begin
            n.rem = rem2 - {1'b0, d};
            n.quo = {s.quo[RECIP_W-2:0], 1'b1};
        end else begin
            n.rem = rem2;
            n.quo = {s.quo[RECIP_W-2:0], 1'b0};
        end
        return n;
    endfunction

endpackage

// File: rtl/recip_sched_if.sv
// Requester-side bundle of the scheduler: request handshake, response strobe and busy.
interface recip_sched_if
    import recip_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [DENOM_W*NREQ-1:0] req_denom;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         resp_valid;
    logic [RECIP_W-1:0]      resp_recip;
    logic                    busy;

    modport master (
        output req_valid, req_denom,
        input  req_ready, resp_valid, resp_recip, busy
    );

    modport slave (
        input  req_valid, req_denom,
        output req_ready, resp_valid, resp_recip, busy
    );
endinterface

// File: rtl/recip16.sv
// Iterative 65536/denom divider; result is stable DIV_ITERS cycles after the start edge.
module recip16
    import recip_sched_pkg::*;
(
    input  logic               clk,
    input  logic               start,
    input  logic [DENOM_W-1:0] denom,
    output logic [RECIP_W-1:0] recip
);
    localparam int unsigned STEP_W = $clog2(DIV_ITERS);

    div_state_t         r_div;
    div_state_t         w_seed;
    div_state_t         w_first;
    div_state_t         w_second;
    logic [DENOM_W-1:0] r_den;
    logic [STEP_W-1:0]  r_steps;

    // Leading dividend bit leaves remainder 1; two more quotient bits resolve on the start edge.
    always_comb begin
        w_seed.rem = REM_W'(1);
        w_seed.quo = '0;
        w_first    = div_step(w_seed, denom);
        w_second   = div_step(w_first, denom);
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_div   <= w_second;
            r_den   <= denom;
            r_steps <= STEP_W'(DIV_ITERS - 1);
        end else if (r_steps != '0) begin
            r_div   <= div_step(r_div, r_den);
            r_steps <= r_steps - 1'b1;
        end
    end

    assign recip = r_div.quo;

endmodule

// File: rtl/recip_sched.sv
// Round-robin scheduler sharing one recip16 divider among NREQ requesters.
// Define RECIP_SCHED_CACHE_EN to add a one-entry result cache that bypasses the divider.
module recip_sched
    import recip_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ITERS = DIV_ITERS
) (
    input  logic         clk,
    input  logic         rst,
    recip_sched_if.slave bus
);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IDX_W = PTR_W + 1;
    localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_e             r_state;
    state_e             w_next;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_idx;
    logic [DENOM_W-1:0] r_denom;
    logic [DENOM_W-1:0] w_win_denom;
    logic [CNT_W-1:0]   r_cnt;
    logic [RECIP_W-1:0] r_recip;
    logic [RECIP_W-1:0] w_div_recip;
    logic [RECIP_W-1:0] w_cache_recip;
    logic               w_found;
    logic               w_arb_en;
    logic               w_accept;
    logic               w_hit;
    logic               w_div_start;
    logic               w_run_last;

    // First valid requester at or after the round-robin pointer, with wrap.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = IDX_W'(r_rr_ptr) + IDX_W'(i);
            if (w_idx >= IDX_W'(NREQ)) begin
                w_idx = w_idx - IDX_W'(NREQ);
            end
            if (!w_found && bus.req_valid[w_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_arb_en    = ((r_state == IDLE) || (r_state == DONE)) && !rst;
    assign w_accept    = w_arb_en && w_found;
    assign w_win_denom = bus.req_denom[w_winner*DENOM_W +: DENOM_W];
    assign w_run_last  = (r_state == RUN) && (r_cnt == '0);

`ifdef RECIP_SCHED_CACHE_EN
    logic               r_cache_vld;
    logic [DENOM_W-1:0] r_cache_denom;
    logic [RECIP_W-1:0] r_cache_recip;

    // Remembers the most recent divider result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_vld   <= 1'b0;
            r_cache_denom <= '0;
            r_cache_recip <= '0;
        end else if (w_run_last) begin
            r_cache_vld   <= 1'b1;
            r_cache_denom <= r_denom;
            r_cache_recip <= w_div_recip;
        end
    end

    assign w_hit         = r_cache_vld && (r_cache_denom == w_win_denom);
    assign w_cache_recip = r_cache_recip;
`else
    assign w_hit         = 1'b0;
    assign w_cache_recip = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_hit ? DONE : LOAD;
                end
            end
            LOAD: w_next = RUN;
            RUN: begin
                if (r_cnt == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_next = w_hit ? DONE : LOAD;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.busy       = 1'b0;
        w_div_start    = 1'b0;
        if (w_accept) begin
            bus.req_ready[w_winner] = 1'b1;
        end
        if ((r_state == DONE) && !rst) begin
            bus.resp_valid[r_owner] = 1'b1;
        end
        bus.busy    = (r_state == LOAD) || (r_state == RUN);
        w_div_start = (r_state == LOAD);
    end

    // Owner/denom latch, rotation pointer, iteration counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_denom  <= '0;
            r_cnt    <= '0;
            r_recip  <= '0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_winner;
                r_denom  <= w_win_denom;
                r_rr_ptr <= (w_winner == PTR_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;
            end
            if (r_state == LOAD) begin
                r_cnt <= CNT_W'(ITERS - 1);
            end else if ((r_state == RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_run_last) begin
                r_recip <= w_div_recip;
            end else if (w_accept && w_hit) begin
                r_recip <= w_cache_recip;
            end
        end
    end

    assign bus.resp_recip = r_recip;

    recip16 u_div (
        .clk   (clk),
        .start (w_div_start),
        .denom (r_denom),
        .recip (w_div_recip)
    );

endmodule
